// File: rtl/div_scheduler.sv
// Two-requester front end for one shared restoring sign-magnitude divider.
// Round-robin grant, req/ack operand capture, one quotient bit per clock.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   reqA/numA/denA/       requester A: level request plus operand
//   signNA/signDA         magnitudes and signs (1 = negative)
//   reqB/numB/denB/       requester B, same meaning as A
//   signNB/signDB
//   ackA, ackB            one-cycle pulse: operands captured
//   doneA, doneB          one-cycle pulse: result valid for that owner
//   result, remainder     quotient / remainder magnitudes
//   sign                  quotient sign (never a negative zero)
//   divZero               last operation had a zero denominator
//   busy                  high whenever the scheduler is not idle
module div_scheduler #(
    parameter int numBits = 8,
    parameter int demBits = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reqA,
    input  logic [numBits-1:0] numA,
    input  logic [demBits-1:0] denA,
    input  logic               signNA,
    input  logic               signDA,
    input  logic               reqB,
    input  logic [numBits-1:0] numB,
    input  logic [demBits-1:0] denB,
    input  logic               signNB,
    input  logic               signDB,
    output logic               ackA,
    output logic               ackB,
    output logic               doneA,
    output logic               doneB,
    output logic [numBits-1:0] result,
    output logic [demBits-1:0] remainder,
    output logic               sign,
    output logic               divZero,
    output logic               busy
);

    localparam int CW = (numBits > 1) ? $clog2(numBits) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               fin_q, fin_d;
    logic               owner_q, owner_d;
    logic               last_b_q, last_b_d;
    logic [numBits-1:0] num_q, num_d;
    logic [demBits-1:0] den_q, den_d;
    logic               sgn_num_q, sgn_num_d;
    logic               sgn_den_q, sgn_den_d;
    logic [demBits-1:0] prem_q, prem_d;
    logic [numBits-1:0] quo_q, quo_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               done_a_q, done_a_d;
    logic               done_b_q, done_b_d;
    logic [numBits-1:0] result_q, result_d;
    logic [demBits-1:0] rem_q, rem_d;
    logic               sign_q, sign_d;
    logic               dz_q, dz_d;

    logic               pick_b;
    logic [numBits-1:0] num_sel;
    logic [demBits-1:0] den_sel;
    logic               sn_sel;
    logic               sd_sel;
    logic [demBits:0]   shifted;
    logic [demBits:0]   trial;
    logic               qbit;

    // Tie goes to whoever was not granted last time.
    assign pick_b  = reqB & (~reqA | ~last_b_q);
    assign num_sel = pick_b ? numB : numA;
    assign den_sel = pick_b ? denB : denA;
    assign sn_sel  = pick_b ? signNB : signNA;
    assign sd_sel  = pick_b ? signDB : signDA;

    // Partial remainder stays below den, so the trial lies in (-den, den)
    // and its top bit is a valid borrow flag.
    assign shifted = {prem_q, num_q[count_q]};
    assign trial   = shifted - {1'b0, den_q};
    assign qbit    = ~trial[demBits];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        fin_d     = fin_q;
        owner_d   = owner_q;
        last_b_d  = last_b_q;
        num_d     = num_q;
        den_d     = den_q;
        sgn_num_d = sgn_num_q;
        sgn_den_d = sgn_den_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        result_d  = result_q;
        rem_d     = rem_q;
        sign_d    = sign_q;
        dz_d      = dz_q;
        unique case (state_q)
            IDLE: begin
                if (reqA | reqB) begin
                    owner_d   = pick_b;
                    last_b_d  = pick_b;
                    num_d     = num_sel;
                    den_d     = den_sel;
                    sgn_num_d = sn_sel;
                    sgn_den_d = sd_sel;
                    ack_a_d   = ~pick_b;
                    ack_b_d   = pick_b;
                    prem_d    = '0;
                    quo_d     = '0;
                    count_d   = CW'(numBits - 1);
                    // A zero divisor skips the bit loop entirely.
                    fin_d     = (den_sel == '0);
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (fin_q) begin
                    state_d  = DONE;
                    done_a_d = ~owner_q;
                    done_b_d = owner_q;
                    if (den_q == '0) begin
                        result_d = '1;
                        rem_d    = '0;
                        dz_d     = 1'b1;
                        sign_d   = sgn_num_q ^ sgn_den_q;
                    end else begin
                        result_d = quo_q;
                        rem_d    = prem_q;
                        dz_d     = 1'b0;
                        sign_d   = (sgn_num_q ^ sgn_den_q) & (|quo_q);
                    end
                end else begin
                    quo_d[count_q] = qbit;
                    prem_d = qbit ? trial[demBits-1:0]
                                  : shifted[demBits-1:0];
                    if (count_q == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            fin_q     <= 1'b0;
            owner_q   <= 1'b0;
            last_b_q  <= 1'b1;
            num_q     <= '0;
            den_q     <= '0;
            sgn_num_q <= 1'b0;
            sgn_den_q <= 1'b0;
            prem_q    <= '0;
            quo_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            result_q  <= '0;
            rem_q     <= '0;
            sign_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            fin_q     <= fin_d;
            owner_q   <= owner_d;
            last_b_q  <= last_b_d;
            num_q     <= num_d;
            den_q     <= den_d;
            sgn_num_q <= sgn_num_d;
            sgn_den_q <= sgn_den_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            sign_q    <= sign_d;
            dz_q      <= dz_d;
        end
    end

    assign ackA      = ack_a_q;
    assign ackB      = ack_b_q;
    assign doneA     = done_a_q;
    assign doneB     = done_b_q;
    assign result    = result_q;
    assign remainder = rem_q;
    assign sign      = sign_q;
    assign divZero   = dz_q;
    assign busy      = (state_q != IDLE);

endmodule
